fft_twiddle_gen: RTL and testbench

//  Parametrised twiddle-factor generator for the radix-2 FFT datapath.

---
 rtl/fft_twiddle_gen.sv | 161 ++++++++++++++++
 tb/tb_fft_twiddle_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_gen.sv
// fft_twiddle_gen
//   Twiddle-factor generator for a radix-2 FFT of up to N = 2^LOG2_N points.
//   A single quarter-wave cosine table Q[0..N/4] is built at elaboration and
//   both parts of W = cos(2*pi*k/N) -/+ j*sin(2*pi*k/N) are derived by symmetry.
//   Three-stage pipeline (address / ROM read / sign apply) with a valid/ready
//   handshake on both sides; the whole pipe freezes while the output is stalled.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (req_ready = !tw_valid | tw_ready)
//   req_stage              FFT stage s, legal 1..LOG2_N
//   req_idx                butterfly index j, legal 0..2^(s-1)-1
//   req_inv                0 = forward (im = -sin), 1 = inverse (im = +sin)
//   tw_valid/tw_ready      output handshake
//   tw_re, tw_im           twiddle, two's complement with FRAC_W fraction bits
//   tw_err                 request was illegal; tw_re/tw_im are 0
module fft_twiddle_gen #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LOG2_N = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LOG2_N-1:0] req_stage,
  input  logic [LOG2_N-2:0] req_idx,
  input  logic              req_inv,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic              tw_err
);

  localparam int N   = 1 << LOG2_N;
  localparam int A_W = LOG2_N - 1;   // addresses 0..N/4, and k in 0..N/2-1

  localparam logic [A_W-1:0]    QTR   = A_W'(N / 4);
  localparam logic [LOG2_N-1:0] S_MAX = LOG2_N'(LOG2_N);
  localparam logic [LOG2_N-1:0] S_ONE = LOG2_N'(1);

  typedef logic [N/4:0][DATA_W-1:0] tab_t;

  // Quarter-wave cosine table, Q[m] = round(cos(2*pi*m/N) * 2^FRAC_W).
  // Evaluated with an integer Taylor series in Q28 so that elaboration needs
  // no real-valued math support from the tools.
  function automatic tab_t build_table();
    tab_t   t;
    longint pi_f;
    longint x;
    longint x2;
    longint term;
    longint sum;
    pi_f = 64'sd843314857;  // round(pi * 2^28)
    t    = '0;
    for (int unsigned m = 0; m <= N / 4; m++) begin
      x    = (64'sd2 * pi_f * longint'(m)) >>> LOG2_N;
      x2   = (x * x) >>> 28;
      term = 64'sd1 <<< 28;
      sum  = term;
      for (int unsigned i = 1; i <= 10; i++) begin
        term = -((term * x2) >>> 28) / longint'((2 * i - 1) * (2 * i));
        sum  = sum + term;
      end
      t[m] = DATA_W'(((sum <<< FRAC_W) + (64'sd1 <<< 27)) >>> 28);
    end
    return t;
  endfunction

  localparam tab_t QTAB = build_table();

  logic en;
  assign en        = !tw_valid || tw_ready;
  assign req_ready = en;

  // ---------------------------------------------------------------- request decode
  logic [LOG2_N-1:0] shl;
  logic [LOG2_N-1:0] shr;
  logic              s_ok;
  logic              j_ok;
  logic              req_err;
  logic [A_W-1:0]    k;
  logic [A_W-1:0]    cos_addr_d;
  logic [A_W-1:0]    sin_addr_d;

  always_comb begin
    shl     = S_MAX - req_stage;
    shr     = req_stage - S_ONE;
    s_ok    = (req_stage != '0) && (req_stage <= S_MAX);
    j_ok    = (req_idx >> shr) == '0;
    req_err = !(s_ok && j_ok);
    k       = req_idx << shl;
    // N/4 is a power of two, so the top bit of k is exactly k >= N/4.
    // For that half, N/2 - k wraps to -k in A_W bits.
    if (k[A_W-1]) begin
      cos_addr_d = -k;
      sin_addr_d = k - QTR;
    end else begin
      cos_addr_d = k;
      sin_addr_d = QTR - k;
    end
  end

  // ---------------------------------------------------------------- pipeline
  logic              v1;
  logic              v2;
  logic [A_W-1:0]    p1_cos_addr;
  logic [A_W-1:0]    p1_sin_addr;
  logic              p1_cos_neg;
  logic              p1_im_neg;
  logic              p1_err;
  logic [DATA_W-1:0] p2_cos;
  logic [DATA_W-1:0] p2_sin;
  logic              p2_cos_neg;
  logic              p2_im_neg;
  logic              p2_err;

  logic [DATA_W-1:0] re_d;
  logic [DATA_W-1:0] im_d;

  always_comb begin
    re_d = p2_cos_neg ? -p2_cos : p2_cos;
    im_d = p2_im_neg  ? -p2_sin : p2_sin;
  end

  // Data path registers: no reset, only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      p1_cos_addr <= cos_addr_d;
      p1_sin_addr <= sin_addr_d;
      p1_cos_neg  <= k[A_W-1];
      p1_im_neg   <= !req_inv;
      p1_err      <= req_err;
      p2_cos      <= QTAB[p1_cos_addr];
      p2_sin      <= QTAB[p1_sin_addr];
      p2_cos_neg  <= p1_cos_neg;
      p2_im_neg   <= p1_im_neg;
      p2_err      <= p1_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      tw_valid <= 1'b0;
      tw_err   <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
    end else if (en) begin
      v1       <= req_valid;
      v2       <= v1;
      tw_valid <= v2;
      tw_err   <= v2 && p2_err;
      tw_re    <= (v2 && !p2_err) ? re_d : '0;
      tw_im    <= (v2 && !p2_err) ? im_d : '0;
    end
  end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
module tb_fft_twiddle_gen;

  localparam int  NPTS = 32;
  localparam real PI   = 3.14159265358979323846;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_stage;
  logic [3:0]  req_idx;
  logic        req_inv;
  logic        tw_valid;
  logic        tw_ready;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic        tw_err;

  int n_checks;
  int n_pass;

  int          req_s_q[$];
  int          req_j_q[$];
  bit          req_inv_q[$];
  logic [15:0] got_re_q[$];
  logic [15:0] got_im_q[$];
  logic        got_err_q[$];

  fft_twiddle_gen #(.DATA_W(16), .FRAC_W(8), .LOG2_N(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_stage(req_stage),
    .req_idx  (req_idx),
    .req_inv  (req_inv),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_err   (tw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: twiddle computed directly from cos/sin of the angle.
  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic void model(input int s, input int j, input bit inv,
                                output logic [15:0] re, output logic [15:0] im,
                                output logic err);
    int  k;
    real ang;
    if (s < 1 || s > 5 || j >= (1 << (s - 1))) begin
      err = 1'b1;
      re  = 16'h0000;
      im  = 16'h0000;
    end else begin
      k   = j * (1 << (5 - s));
      ang = 2.0 * PI * real'(k) / real'(NPTS);
      err = 1'b0;
      re  = 16'(rnd($cos(ang) * 256.0));
      im  = inv ? 16'(rnd($sin(ang) * 256.0)) : 16'(-rnd($sin(ang) * 256.0));
    end
  endfunction

  // Drives the queued requests with random gaps/back-pressure and records every
  // output beat; starts and ends at a falling edge.
  task automatic drive_stream(input int valid_pct, input int ready_pct,
                              input int max_cycles, output int cycles,
                              output bit timeout);
    int sent;
    int n;
    n       = req_s_q.size();
    sent    = 0;
    cycles  = 0;
    timeout = 1'b0;
    got_re_q.delete();
    got_im_q.delete();
    got_err_q.delete();
    while ((sent < n || got_re_q.size() < n) && !timeout) begin
      if (sent < n && $urandom_range(99) < valid_pct) begin
        req_valid = 1'b1;
        req_stage = 5'(req_s_q[sent]);
        req_idx   = 4'(req_j_q[sent]);
        req_inv   = req_inv_q[sent];
      end else begin
        req_valid = 1'b0;
      end
      tw_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (req_valid && req_ready) sent++;
      if (tw_valid && tw_ready) begin
        got_re_q.push_back(tw_re);
        got_im_q.push_back(tw_im);
        got_err_q.push_back(tw_err);
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (cycles > max_cycles) timeout = 1'b1;
    end
    // Drain window: anything that still appears is an extra (duplicated) beat.
    req_valid = 1'b0;
    tw_ready  = 1'b1;
    repeat (5) begin
      #1;
      if (tw_valid) begin
        got_re_q.push_back(tw_re);
        got_im_q.push_back(tw_im);
        got_err_q.push_back(tw_err);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_stage = 5'd5;
    req_idx   = 4'd0;
    req_inv   = 1'b0;
    tw_ready  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({tw_valid, tw_err, tw_re, tw_im} !== 34'd0) begin
        $display("FAIL reset_outputs_%0d: got valid=%b err=%b re=%h im=%h, expected all 0",
                 c, tw_valid, tw_err, tw_re, tw_im);
      end else n_pass++;
      n_checks++;
      if (req_ready !== 1'b1) begin
        $display("FAIL reset_ready_%0d: got %b, expected 1", c, req_ready);
      end else n_pass++;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      n_checks++;
      if (tw_valid !== (c == 3)) begin
        $display("FAIL reset_first_out_edge%0d: got tw_valid=%b, expected %b", c, tw_valid, (c == 3));
      end else n_pass++;
    end
    n_checks++;
    if ({tw_err, tw_re, tw_im} !== {1'b0, 16'h0100, 16'h0000}) begin
      $display("FAIL reset_first_value: got err=%b re=%h im=%h, expected err=0 re=0100 im=0000",
               tw_err, tw_re, tw_im);
    end else n_pass++;
  endtask

  task automatic test_directed();
    int          ds [6];
    int          dj [6];
    bit          di [6];
    logic [15:0] dre[6];
    logic [15:0] dim[6];
    int          lat;
    ds  = '{5, 2, 5, 5, 5, 5};
    dj  = '{0, 1, 4, 4, 12, 15};
    di  = '{0, 0, 0, 1, 0, 0};
    dre = '{16'h0100, 16'h0000, 16'h00B5, 16'h00B5, 16'hFF4B, 16'hFF05};
    dim = '{16'h0000, 16'hFF00, 16'hFF4B, 16'h00B5, 16'hFF4B, 16'hFFCE};
    for (int v = 0; v < 6; v++) begin
      req_valid = 1'b1;
      req_stage = 5'(ds[v]);
      req_idx   = 4'(dj[v]);
      req_inv   = di[v];
      tw_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat       = 1;
      while (!tw_valid && lat < 10) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat !== 3) begin
        $display("FAIL directed_latency_%0d: got %0d edges, expected 3", v, lat);
      end else n_pass++;
      n_checks++;
      if ({tw_err, tw_re, tw_im} !== {1'b0, dre[v], dim[v]}) begin
        $display("FAIL directed_%0d (s=%0d j=%0d inv=%0d): got err=%b re=%h im=%h, expected err=0 re=%h im=%h",
                 v, ds[v], dj[v], di[v], tw_err, tw_re, tw_im, dre[v], dim[v]);
      end else n_pass++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          cycles;
    bit          timeout;
    logic [15:0] ere;
    logic [15:0] eim;
    logic        eerr;
    for (int pass = 0; pass < 2; pass++) begin
      req_s_q.delete();
      req_j_q.delete();
      req_inv_q.delete();
      for (int j = 0; j < 16; j++) begin
        req_s_q.push_back(5);
        req_j_q.push_back(j);
        req_inv_q.push_back(1'($urandom_range(1)));
      end
      drive_stream(100, (pass == 0) ? 50 : 100, 500, cycles, timeout);
      n_checks++;
      if (timeout || got_re_q.size() != 16) begin
        $display("FAIL b2b_count_%0d: got %0d outputs (timeout=%0d), expected 16",
                 pass, got_re_q.size(), timeout);
      end else n_pass++;
      if (pass == 1) begin
        n_checks++;
        if (cycles != 19) begin
          $display("FAIL b2b_throughput: got %0d cycles, expected 19", cycles);
        end else n_pass++;
      end
      for (int i = 0; i < 16 && i < got_re_q.size(); i++) begin
        model(req_s_q[i], req_j_q[i], req_inv_q[i], ere, eim, eerr);
        n_checks++;
        if ({got_err_q[i], got_re_q[i], got_im_q[i]} !== {eerr, ere, eim}) begin
          $display("FAIL b2b_%0d_j%0d: got err=%b re=%h im=%h, expected err=%b re=%h im=%h",
                   pass, i, got_err_q[i], got_re_q[i], got_im_q[i], eerr, ere, eim);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    int          cycles;
    bit          timeout;
    logic [15:0] ere;
    logic [15:0] eim;
    logic        eerr;
    req_s_q   = '{5, 0, 4, 6, 3, 3, 1};
    req_j_q   = '{1, 0, 3, 0, 4, 3, 0};
    req_inv_q = '{0, 0, 1, 0, 0, 1, 0};
    drive_stream(100, 70, 300, cycles, timeout);
    n_checks++;
    if (timeout || got_re_q.size() != 7) begin
      $display("FAIL illegal_count: got %0d outputs (timeout=%0d), expected 7",
               got_re_q.size(), timeout);
    end else n_pass++;
    for (int i = 0; i < 7 && i < got_re_q.size(); i++) begin
      model(req_s_q[i], req_j_q[i], req_inv_q[i], ere, eim, eerr);
      n_checks++;
      if ({got_err_q[i], got_re_q[i], got_im_q[i]} !== {eerr, ere, eim}) begin
        $display("FAIL illegal_%0d (s=%0d j=%0d): got err=%b re=%h im=%h, expected err=%b re=%h im=%h",
                 i, req_s_q[i], req_j_q[i], got_err_q[i], got_re_q[i], got_im_q[i], eerr, ere, eim);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    int          cycles;
    bit          timeout;
    int          s;
    logic [15:0] ere;
    logic [15:0] eim;
    logic        eerr;
    req_s_q.delete();
    req_j_q.delete();
    req_inv_q.delete();
    for (int i = 0; i < 40; i++) begin
      s = ($urandom_range(99) < 80) ? int'($urandom_range(5, 1)) : int'($urandom_range(31));
      req_s_q.push_back(s);
      if (s >= 1 && s <= 5 && $urandom_range(99) < 75)
        req_j_q.push_back(int'($urandom_range((1 << (s - 1)) - 1)));
      else
        req_j_q.push_back(int'($urandom_range(15)));
      req_inv_q.push_back(1'($urandom_range(1)));
    end
    drive_stream(70, 60, 2000, cycles, timeout);
    n_checks++;
    if (timeout || got_re_q.size() != 40) begin
      $display("FAIL random_count: got %0d outputs (timeout=%0d), expected 40",
               got_re_q.size(), timeout);
    end else n_pass++;
    for (int i = 0; i < 40 && i < got_re_q.size(); i++) begin
      model(req_s_q[i], req_j_q[i], req_inv_q[i], ere, eim, eerr);
      n_checks++;
      if ({got_err_q[i], got_re_q[i], got_im_q[i]} !== {eerr, ere, eim}) begin
        $display("FAIL random_%0d (s=%0d j=%0d inv=%0d): got err=%b re=%h im=%h, expected err=%b re=%h im=%h",
                 i, req_s_q[i], req_j_q[i], req_inv_q[i], got_err_q[i], got_re_q[i], got_im_q[i],
                 eerr, ere, eim);
      end else n_pass++;
    end
  endtask

  task automatic test_flush();
    tw_ready  = 1'b1;
    req_valid = 1'b1;
    req_stage = 5'd5;
    req_idx   = 4'd1;
    req_inv   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_idx = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL flush_ready: got %b, expected 1", req_ready);
    end else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (tw_valid !== 1'b0) begin
        $display("FAIL flush_cycle_%0d: got tw_valid=%b, expected 0", c, tw_valid);
      end else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_illegal();
    test_random();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
